uart_tx_drain: RTL and testbench
================================

Name: uart_tx_drain

Overview:
- Downstream consumer of the 8-entry byte FIFO. Pops one byte at a time over the FIFO's re/empty/out interface.
- Serialises each byte as an asynchronous UART frame on txd: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Sits between the byte FIFO and the chip-level serial pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  permits fetching new bytes; does not abort a frame already in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_re  output  1  FIFO read strobe.
- fifo_data  input  8  FIFO registered read data; valid in the cycle after fifo_re=1 with fifo_empty=0.
- txd  output  1  serial line; idle high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse in the last clk of the final stop bit.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, txd=1, bit counter=0, baud counter=0.
  - busy=0, tx_done=0.
  - fifo_re is forced 0 in any cycle where rst=1.
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- fifo_re is combinational: (state==IDLE) && enable && !fifo_empty && !rst.
  - Never asserted while fifo_empty=1.
  - Never asserted for more than one cycle per frame.
- IDLE -> LOAD: on the edge where fifo_re=1.
- LOAD: lasts exactly one cycle.
  - fifo_data is captured into an 8-bit shift register.
  - Parity is computed from the captured byte: XOR of bits, inverted if PARITY_ODD.
  - Next state is START.
- txd is a register updated on the same edge as the state transition, so its value tracks the state entered:
  - START: 0.
  - DATA: current LSB of the shift register.
  - PARITY: parity bit.
  - STOP and IDLE: 1.
- Baud counter (width clog2(CLKS_PER_BIT)):
  - Counts 0..CLKS_PER_BIT-1 in START, DATA, PARITY and STOP.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - The counter clears on each bit transition.
- DATA:
  - The 3-bit bit counter advances 0..7; the shift register shifts right at each bit end.
  - After bit 7: go to PARITY if PARITY_EN, else STOP.
- PARITY: one bit time, then STOP.
- STOP: lasts STOP_BITS x CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle of STOP.
  - Next state is IDLE.
- Latency: fifo_re high in cycle T -> LOAD in T+1 -> txd falls at the start of T+2.
- Back-to-back frames: with data available and enable=1, the next start bit begins exactly 2 cycles after the last stop bit ends (one IDLE cycle + one LOAD cycle, txd high throughout).
- enable dropped mid-frame: the frame completes normally; no new fetch occurs until enable=1.
- fifo_empty toggling mid-frame: ignored.
- fifo_data outside LOAD: ignored. The FIFO drives 0 there.
- rst mid-frame: the frame is aborted with no tx_done pulse.
  - txd=1 from the next edge.
  - The byte already popped is discarded.
- Frame length in cycles: CLKS_PER_BIT x (10 + PARITY_EN + STOP_BITS - 1).

Test Plan:
- Single byte 0xA5 (CLKS_PER_BIT=4, no parity, STOP_BITS=1):
  - fifo_re is high exactly one cycle; txd goes low 2 cycles later.
  - txd sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1 (40 cycles).
  - tx_done pulses in cycle 40 of the frame; busy=1 for LOAD plus all 40 frame cycles.
- Parity with 0xA5 (PARITY_EN=1):
  - PARITY_ODD=0 gives parity bit 0; PARITY_ODD=1 gives parity bit 1.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back 0x01 then 0x80 preloaded:
  - Exactly two fifo_re pulses.
  - Second fifo_re occurs in the cycle after the first stop bit ends.
  - txd is high for CLKS_PER_BIT+2 cycles between frames.
- Empty FIFO, enable=1 for 100 cycles: fifo_re=0, txd=1, busy=0 throughout.
- enable deasserted in mid-DATA with 2 bytes queued:
  - The current frame completes; no further fifo_re.
  - Re-asserting enable starts the second byte with the standard 2-cycle latency.
- rst asserted during DATA bit 3:
  - Next cycle: txd=1, busy=0, tx_done never pulses.
  - A following byte transmits correctly from START.

Source files
------------

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an 8-entry byte FIFO and serialises each byte
// as start + 8 data bits (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx_drain #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_re,
    input  logic [7:0] fifo_data,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              tx_done_q, tx_done_d;
    logic              bit_end;

    // Pop strobe is combinational so the FIFO sees it in the IDLE cycle itself.
    assign fifo_re = (state_q == S_IDLE) && enable && !fifo_empty && !rst;
    assign bit_end = (baud_q == BAUD_LAST);

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

    // Next-state logic; txd_d always reflects the line level of the state being entered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        txd_d    = txd_q;

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                baud_d = '0;
                bit_d  = 3'd0;
                if (fifo_re) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d  = fifo_data;
                parity_d = (^fifo_data) ^ PAR_ODD;
                state_d  = S_START;
                txd_d    = 1'b0;
                baud_d   = '0;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                baud_d  = '0;
                bit_d   = 3'd0;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        // Registered pulse lands on the last cycle of the final stop bit.
        tx_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three configurations share one byte stream, each with
// its own FIFO read pointer; a negedge monitor checks every line cycle against frame rules.
module tb_uart_tx_drain;

    localparam int unsigned CPB0 = 4, PE0 = 0, ODD0 = 0, SB0 = 1;
    localparam int unsigned CPB1 = 3, PE1 = 1, ODD1 = 1, SB1 = 2;
    localparam int unsigned CPB2 = 2, PE2 = 1, ODD2 = 0, SB2 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_re;
    logic [7:0] fifo_data [3];
    logic [2:0] txd;
    logic [2:0] busy;
    logic [2:0] tx_done;

    logic [7:0] mem [1024];
    int         wr_ptr = 0;
    int         rd_ptr [3] = '{0, 0, 0};
    logic       stim_done = 1'b0;
    logic       timeout_flag = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_drain #(.CLKS_PER_BIT(CPB0), .PARITY_EN(PE0), .PARITY_ODD(ODD0), .STOP_BITS(SB0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[0]), .fifo_re(fifo_re[0]),
        .fifo_data(fifo_data[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(tx_done[0]));
    uart_tx_drain #(.CLKS_PER_BIT(CPB1), .PARITY_EN(PE1), .PARITY_ODD(ODD1), .STOP_BITS(SB1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[1]), .fifo_re(fifo_re[1]),
        .fifo_data(fifo_data[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(tx_done[1]));
    uart_tx_drain #(.CLKS_PER_BIT(CPB2), .PARITY_EN(PE2), .PARITY_ODD(ODD2), .STOP_BITS(SB2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[2]), .fifo_re(fifo_re[2]),
        .fifo_data(fifo_data[2]), .txd(txd[2]), .busy(busy[2]), .tx_done(tx_done[2]));

    assign fifo_empty[0] = (wr_ptr == rd_ptr[0]);
    assign fifo_empty[1] = (wr_ptr == rd_ptr[1]);
    assign fifo_empty[2] = (wr_ptr == rd_ptr[2]);

    // FIFO models: registered read data, zero when not popping.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fifo_re[i] && !fifo_empty[i]) begin
                fifo_data[i] <= mem[rd_ptr[i] & 1023];
                rd_ptr[i]    <= rd_ptr[i] + 1;
            end else begin
                fifo_data[i] <= 8'h00;
            end
        end
    end

    function automatic int cpb_of(input int i);
        case (i)
            0: return int'(CPB0);
            1: return int'(CPB1);
            default: return int'(CPB2);
        endcase
    endfunction

    function automatic int pe_of(input int i);
        case (i)
            0: return int'(PE0);
            1: return int'(PE1);
            default: return int'(PE2);
        endcase
    endfunction

    function automatic int odd_of(input int i);
        case (i)
            0: return int'(ODD0);
            1: return int'(ODD1);
            default: return int'(ODD2);
        endcase
    endfunction

    function automatic int sb_of(input int i);
        case (i)
            0: return int'(SB0);
            1: return int'(SB1);
            default: return int'(SB2);
        endcase
    endfunction

    function automatic int frame_len(input int i);
        return cpb_of(i) * (10 + pe_of(i) + sb_of(i) - 1);
    endfunction

    // Expected line level at cycle c of a frame carrying byte b.
    function automatic int exp_line(input int i, input logic [7:0] b, input int c);
        int slot;
        int ones;
        slot = c / cpb_of(i);
        if (slot == 0) return 0;
        if (slot <= 8) return int'(b[slot-1]);
        if (pe_of(i) != 0 && slot == 9) begin
            ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(b[k]);
            return (ones % 2) ^ odd_of(i);
        end
        return 1;
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, i, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    initial begin : monitor
        logic [7:0] exp_q [3][$];
        logic [7:0] rx [3];
        logic [7:0] head;
        int mode [3];
        int cyc [3];
        logic rst_prev;
        rst_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0;
            cyc[i]  = 0;
            rx[i]   = 8'h00;
        end
        forever begin
            @(negedge clk);
            if (stim_done) begin
                for (int i = 0; i < 3; i++) chk("sb_drained", i, exp_q[i].size(), 0);
                chk("timeout", 0, int'(timeout_flag), 0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    chk("re_in_reset", i, int'(fifo_re[i]), 0);
                    if (rst_prev) begin
                        chk("rst_txd", i, int'(txd[i]), 1);
                        chk("rst_busy", i, int'(busy[i]), 0);
                        chk("rst_done", i, int'(tx_done[i]), 0);
                    end
                    mode[i] = 0;
                    exp_q[i].delete();
                end else begin
                    case (mode[i])
                        0: begin
                            chk("idle_txd", i, int'(txd[i]), 1);
                            chk("idle_busy", i, int'(busy[i]), 0);
                            chk("idle_done", i, int'(tx_done[i]), 0);
                            chk("idle_re", i, int'(fifo_re[i]), int'(enable && !fifo_empty[i]));
                            if (fifo_re[i]) begin
                                exp_q[i].push_back(mem[rd_ptr[i] & 1023]);
                                mode[i] = 1;
                            end
                        end
                        1: begin
                            chk("load_txd", i, int'(txd[i]), 1);
                            chk("load_busy", i, int'(busy[i]), 1);
                            chk("load_re", i, int'(fifo_re[i]), 0);
                            mode[i] = 2;
                            cyc[i]  = 0;
                        end
                        default: begin
                            if (exp_q[i].size() == 0) begin
                                chk("sb_underflow", i, 0, 1);
                                mode[i] = 0;
                            end else begin
                                head = exp_q[i][0];
                                chk("frame_txd", i, int'(txd[i]), exp_line(i, head, cyc[i]));
                                chk("frame_busy", i, int'(busy[i]), 1);
                                chk("frame_re", i, int'(fifo_re[i]), 0);
                                chk("frame_done", i, int'(tx_done[i]),
                                    int'(cyc[i] == frame_len(i) - 1));
                                if (cyc[i] >= cpb_of(i) && cyc[i] < 9 * cpb_of(i)
                                    && (cyc[i] % cpb_of(i)) == cpb_of(i) / 2)
                                    rx[i][cyc[i] / cpb_of(i) - 1] = txd[i];
                                if (cyc[i] == frame_len(i) - 1) begin
                                    head = exp_q[i].pop_front();
                                    chk("frame_byte", i, int'(rx[i]), int'(head));
                                    mode[i] = 0;
                                end else begin
                                    cyc[i] = cyc[i] + 1;
                                end
                            end
                        end
                    endcase
                end
            end
            rst_prev = rst;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr & 1023] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic int occupancy();
        int m;
        m = 0;
        for (int i = 0; i < 3; i++)
            if (wr_ptr - rd_ptr[i] > m) m = wr_ptr - rd_ptr[i];
        return m;
    endfunction

    // Wait for every FIFO to empty and every transmitter to return to idle.
    task automatic drain();
        int quiet;
        quiet = 0;
        for (int k = 0; k < 3000 && quiet < 3; k++) begin
            step(1);
            if (fifo_empty == 3'b111 && busy == 3'b000) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) timeout_flag = 1'b1;
    endtask

    initial begin : stimulus
        rst    = 1'b1;
        enable = 1'b0;
        step(3);
        rst    = 1'b0;
        enable = 1'b1;
        step(100);

        push(8'hA5);
        drain();

        push(8'h01);
        push(8'h80);
        drain();

        push(8'h3C);
        push(8'hC3);
        step(12);
        enable = 1'b0;
        step(80);
        enable = 1'b1;
        drain();

        push(8'h5A);
        push(8'h96);
        step(18);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        drain();

        for (int it = 0; it < 40; it++) begin
            int n;
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++)
                if (occupancy() < 8) push(8'($urandom));
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            step(int'($urandom_range(1, 60)));
        end
        enable = 1'b1;
        drain();
        step(2);
        stim_done = 1'b1;
    end

endmodule
